// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width, opcode
// encoding and the result pattern reported on the ABCD flag.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [31:0] ABCD_PATTERN = 32'h0000ABCD;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRA  = 3'd6,
        ALU_ADD2 = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational five-stage barrel shifter: logical left shift, or arithmetic
// (sign-filled) right shift when arith is set. Only the low 5 amount bits exist.
module alu_shifter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] stage [6];

    assign stage[0] = a;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int N = 1 << k;
        logic [WIDTH-1:0] shl;
        logic [WIDTH-1:0] sra;

        assign shl = {stage[k][WIDTH-1-N:0], {N{1'b0}}};
        assign sra = {{N{stage[k][WIDTH-1]}}, stage[k][WIDTH-1:N]};
        assign stage[k+1] = !shamt[k] ? stage[k] : (arith ? sra : shl);
    end

    assign y = stage[5];

endmodule

// File: rtl/alu.sv
// Execute-stage ALU with one-cycle registered result, zero and 0xABCD flags.
// Defining ALU_EXT_FLAGS_EN adds registered N/C/V status outputs.
module alu #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       ALUcontrol,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Output,
    output logic             Z,
    output logic             ABCD,
`ifdef ALU_EXT_FLAGS_EN
    output logic             N,
    output logic             C,
    output logic             V,
`endif
    output logic             out_valid
);
    import alu_pkg::*;

    alu_op_e          op;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [WIDTH-1:0] shift_y;
    logic [WIDTH-1:0] result;

    assign op = alu_op_e'(ALUcontrol);

`ifdef ALU_EXT_FLAGS_EN
    logic add_c;
    logic sub_c;
    logic c_next;
    logic v_next;

    // Subtract as A + ~B + 1 so the carry out is directly NOT borrow.
    assign {add_c, add_sum}  = {1'b0, A} + {1'b0, B};
    assign {sub_c, sub_diff} = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
`else
    assign add_sum  = A + B;
    assign sub_diff = A - B;
`endif

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a     (A),
        .shamt (B[4:0]),
        .arith (op == ALU_SRA),
        .y     (shift_y)
    );

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD, ALU_ADD2: result = add_sum;
            ALU_SUB:           result = sub_diff;
            ALU_AND:           result = A & B;
            ALU_OR:            result = A | B;
            ALU_XOR:           result = A ^ B;
            ALU_SLL, ALU_SRA:  result = shift_y;
            default:           result = '0;
        endcase
    end

`ifdef ALU_EXT_FLAGS_EN
    always_comb begin
        c_next = 1'b0;
        v_next = 1'b0;
        unique case (op)
            ALU_ADD, ALU_ADD2: begin
                c_next = add_c;
                v_next = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_SUB: begin
                c_next = sub_c;
                v_next = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
            default: begin
                c_next = 1'b0;
                v_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            N <= 1'b0;
            C <= 1'b0;
            V <= 1'b0;
        end else if (in_valid) begin
            N <= result[WIDTH-1];
            C <= c_next;
            V <= v_next;
        end
    end
`endif

    // Flags come from the same value that is registered into Output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Output    <= '0;
            Z         <= 1'b0;
            ABCD      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Output <= result;
                Z      <= (result == '0);
                ABCD   <= (result == ABCD_PATTERN);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized traffic against
// an arithmetic reference model. Ext-flag checks compile in with ALU_EXT_FLAGS_EN.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  ALUcontrol = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Output;
    logic        Z;
    logic        ABCD;
    logic        out_valid;
`ifdef ALU_EXT_FLAGS_EN
    logic        N;
    logic        C;
    logic        V;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what the registered outputs should currently hold.
    logic [31:0] exp_out  = '0;
    logic        exp_z    = 1'b0;
    logic        exp_abcd = 1'b0;
    logic        exp_n    = 1'b0;
    logic        exp_c    = 1'b0;
    logic        exp_v    = 1'b0;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .ALUcontrol (ALUcontrol),
        .A          (A),
        .B          (B),
        .Output     (Output),
        .Z          (Z),
        .ABCD       (ABCD),
`ifdef ALU_EXT_FLAGS_EN
        .N          (N),
        .C          (C),
        .V          (V),
`endif
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint d  = longint'(1) << b[4:0];
        longint r;
        case (op)
            0, 7: r = ua + ub;
            1:    r = ua - ub;
            2:    r = longint'(a & b);
            3:    r = longint'(a | b);
            4:    r = longint'(a ^ b);
            5:    r = ua * d;
            default: begin
                r = sa / d;
                if (sa < 0 && (sa % d) != 0) r = r - 1;
            end
        endcase
        return r[31:0];
    endfunction

    task automatic model_accept(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        exp_out  = ref_result(op, a, b);
        exp_z    = (exp_out == 32'd0);
        exp_abcd = (exp_out == 32'h0000ABCD);
        exp_n    = exp_out[31];
        exp_c    = 1'b0;
        exp_v    = 1'b0;
        if (op == 0 || op == 7) begin
            exp_c = (ua + ub) >= (longint'(1) << 32);
            s     = sa + sb;
            exp_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 1) begin
            exp_c = (ua >= ub);
            s     = sa - sb;
            exp_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_ov);
        check({tag, "_out"},   Output,           exp_out);
        check({tag, "_z"},     {31'd0, Z},       {31'd0, exp_z});
        check({tag, "_abcd"},  {31'd0, ABCD},    {31'd0, exp_abcd});
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
`ifdef ALU_EXT_FLAGS_EN
        check({tag, "_n"}, {31'd0, N}, {31'd0, exp_n});
        check({tag, "_c"}, {31'd0, C}, {31'd0, exp_c});
        check({tag, "_v"}, {31'd0, V}, {31'd0, exp_v});
`endif
    endtask

    // Present one operation, let it be clocked in, then check just after the edge.
    task automatic issue(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        ALUcontrol = 3'(op);
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        model_accept(op, a, b);
        check_outputs(tag, 1'b1);
    endtask

    task automatic idle(input string tag);
        in_valid   = 1'b0;
        ALUcontrol = 3'($urandom_range(0, 7));
        A          = $urandom;
        B          = $urandom;
        @(posedge clk);
        #1;
        check_outputs(tag, 1'b0);
    endtask

    task automatic model_reset();
        exp_out  = '0;
        exp_z    = 1'b0;
        exp_abcd = 1'b0;
        exp_n    = 1'b0;
        exp_c    = 1'b0;
        exp_v    = 1'b0;
    endtask

    initial begin
        int op;
        logic [31:0] a;
        logic [31:0] b;

        #1;
        check_outputs("rst_init", 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue("first_after_rst", 0, 32'd1, 32'd2);
        check("first_after_rst_lit", Output, 32'd3);

        // Back-to-back ops 0..4
        issue("bb_add", 0, 32'd30, 32'd20); check("bb_add_lit", Output, 32'd50);
        issue("bb_sub", 1, 32'd30, 32'd20); check("bb_sub_lit", Output, 32'd10);
        issue("bb_and", 2, 32'd30, 32'd20); check("bb_and_lit", Output, 32'd20);
        issue("bb_or",  3, 32'd30, 32'd20); check("bb_or_lit",  Output, 32'd30);
        issue("bb_xor", 4, 32'd30, 32'd20); check("bb_xor_lit", Output, 32'd10);

        issue("sll", 5, 32'd30, 32'd20);        check("sll_lit", Output, 32'd31457280);
        issue("sra", 6, -32'sd4, 32'd1);        check("sra_lit", Output, 32'hFFFFFFFE);
        issue("zero", 7, -32'sd4, 32'd4);       check("zero_lit_z", {31'd0, Z}, 32'd1);
        issue("abcd", 7, 32'h0000ABCD, 32'd0);  check("abcd_lit", {31'd0, ABCD}, 32'd1);
        issue("wrap", 0, 32'h7FFFFFFF, 32'd1);  check("wrap_lit", Output, 32'h80000000);
`ifdef ALU_EXT_FLAGS_EN
        check("wrap_v_lit", {31'd0, V}, 32'd1);
        check("wrap_n_lit", {31'd0, N}, 32'd1);
`endif
        issue("mask", 5, 32'd1, 32'd33);        check("mask_lit", Output, 32'd2);
        issue("sra_zero", 6, 32'h80001234, 32'd64);
        issue("sub_borrow", 1, 32'd3, 32'd5);

        idle("hold0");
        idle("hold1");
        idle("hold2");

        // Reset mid-stream: must clear immediately, and discard the in-flight op.
        in_valid   = 1'b1;
        ALUcontrol = 3'd0;
        A          = 32'd100;
        B          = 32'd200;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 1'b0);
        #2 rst = 1'b0;
        in_valid = 1'b0;
        idle("post_rst_idle");
        issue("post_rst_first", 1, 32'd7, 32'd9);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle("rnd_idle");
            end else begin
                op = int'($urandom_range(0, 7));
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 7))
                    0: a = (op == 1) ? b : -b;
                    1: a = 32'h0000ABCD - b;
                    2: b = 32'($urandom_range(0, 31));
                    default: ;
                endcase
                if ((op == 0 || op == 7) && a == 32'h0000ABCD - b) op = 0;
                issue("rnd", op, a, b);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
